// File: rtl/sdram_wb_bridge.sv
// Wishbone-to-SDRAM-controller bridge: one outstanding access, four-state handshake FSM.
// Define SDRAM_TIMEOUT_EN to enable the WAIT-state watchdog that ends a stuck access with wb_err.
module sdram_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [1:0]  wb_sel,
  input  logic [20:0] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  input  logic        sdram_ready,
  input  logic        sdram_wr_ack,
  input  logic        sdram_rd_ack,
  input  logic [15:0] sys_data_out,
  output logic        sdram_wr_req,
  output logic        sdram_rd_req,
  output logic [21:0] sys_addr,
  output logic [15:0] sys_data_in,
  output logic [1:0]  sdram_byteenable,
  output logic        dqm_h,
  output logic        dqm_l
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} state_e;

  state_e state_q;
  logic   we_q;
  logic   ack_q;
  logic   abort_q;
  logic   ack_match;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign ack_match = we_q ? sdram_wr_ack : sdram_rd_ack;
  // Dropping the strobe deasserts ack in the same cycle the FSM leaves ACK.
  assign wb_ack = ack_q & wb_stb;

`ifdef SDRAM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
  logic       err_q;
  assign wb_err = err_q;
`else
  assign wb_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      we_q             <= 1'b0;
      ack_q            <= 1'b0;
      abort_q          <= 1'b0;
      sdram_wr_req     <= 1'b0;
      sdram_rd_req     <= 1'b0;
      wb_dat_o         <= '0;
      sys_addr         <= '0;
      sys_data_in      <= '0;
      sdram_byteenable <= 2'b11;
      dqm_h            <= 1'b0;
      dqm_l            <= 1'b0;
`ifdef SDRAM_TIMEOUT_EN
      cnt_q            <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q   <= 1'b0;
          abort_q <= 1'b0;
          if (wb_stb && sdram_ready) begin
            we_q         <= wb_we;
            sys_addr     <= {1'b0, wb_adr};
            sys_data_in  <= wb_dat_i;
            sdram_wr_req <= wb_we;
            sdram_rd_req <= ~wb_we;
            if (wb_we) begin
              sdram_byteenable <= wb_sel;
              dqm_h            <= ~wb_sel[1];
              dqm_l            <= ~wb_sel[0];
            end else begin
              sdram_byteenable <= 2'b11;
              dqm_h            <= 1'b0;
              dqm_l            <= 1'b0;
            end
            state_q <= StReq;
          end
        end
        StReq: begin
          if (!wb_stb) abort_q <= 1'b1;
`ifdef SDRAM_TIMEOUT_EN
          cnt_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (!wb_stb) abort_q <= 1'b1;
          if (ack_match) begin
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            if (!we_q) wb_dat_o <= sys_data_out;
            // An abandoned access finishes silently once the controller is done.
            state_q <= (abort_q || !wb_stb) ? StIdle : StAck;
          end
`ifdef SDRAM_TIMEOUT_EN
          else if (cnt_q == TimeoutLast) begin
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            if (!we_q) wb_dat_o <= 16'hFFFF;
            if (abort_q || !wb_stb) begin
              state_q <= StIdle;
            end else begin
              err_q   <= 1'b1;
              state_q <= StAck;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        StAck: begin
          if (!wb_stb) begin
            ack_q   <= 1'b0;
`ifdef SDRAM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= StIdle;
          end else begin
            ack_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Self-checking bench for sdram_wb_bridge: vector table, random transactions against a
// spec-level model, and directed sequences for ready gating, abort, async reset and timeout.
module tb_sdram_wb_bridge;

`ifdef SDRAM_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 16;
`else
  localparam int unsigned TimeoutCycles = 255;
`endif

  logic        clk, rst_n;
  logic        wb_stb, wb_we;
  logic [1:0]  wb_sel;
  logic [20:0] wb_adr;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_ack, wb_err;
  logic        sdram_ready, sdram_wr_ack, sdram_rd_ack;
  logic [15:0] sys_data_out;
  logic        sdram_wr_req, sdram_rd_req;
  logic [21:0] sys_addr;
  logic [15:0] sys_data_in;
  logic [1:0]  sdram_byteenable;
  logic        dqm_h, dqm_l;

  sdram_wb_bridge #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .wb_err(wb_err),
    .sdram_ready(sdram_ready), .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sys_data_out(sys_data_out),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req), .sys_addr(sys_addr),
    .sys_data_in(sys_data_in), .sdram_byteenable(sdram_byteenable),
    .dqm_h(dqm_h), .dqm_l(dqm_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_rd;  // model: most recent value captured into wb_dat_o

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] dat;
    logic [15:0] rdata;
    int          delay;
    logic [21:0] exp_addr;
    logic [1:0]  exp_be;
    logic        exp_dqmh;
    logic        exp_dqml;
    logic [15:0] exp_dato;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // From a negedge with inputs set, wait for a request; returns negedges waited.
  task automatic wait_req(output int n);
    n = 0;
    while (!(sdram_wr_req || sdram_rd_req) && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at the negedge where the request first shows (REQ state).
  task automatic finish_txn(input logic we, input logic [15:0] rdata, input int delay,
                            input logic [15:0] exp_dato);
    for (int i = 0; i < delay; i++) begin
      if (i == delay - 1 && delay >= 2) begin
        sdram_wr_ack = ~we;
        sdram_rd_ack = we;
      end
      @(negedge clk);
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
    end
    chk("req_held", {30'd0, sdram_wr_req, sdram_rd_req}, we ? 32'd2 : 32'd1);
    chk("no_early_ack", {31'd0, wb_ack}, 32'd0);
    sdram_wr_ack = we;
    sdram_rd_ack = ~we;
    sys_data_out = rdata;
    @(negedge clk);
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    sys_data_out = 16'hDEAD;
    chk("req_dropped", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
    chk("ack_m1_low", {31'd0, wb_ack}, 32'd0);
    chk("dat_o", {16'd0, wb_dat_o}, {16'd0, exp_dato});
    @(negedge clk);
    chk("ack_m2_high", {31'd0, wb_ack}, 32'd1);
    chk("err_low", {31'd0, wb_err}, 32'd0);
    wb_stb = 1'b0;
    #1;
    chk("ack_drop_with_stb", {31'd0, wb_ack}, 32'd0);
    if (!we) last_rd = rdata;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    wb_stb = 1'b1; wb_we = v.we; wb_sel = v.sel; wb_adr = v.adr; wb_dat_i = v.dat;
    wait_req(n);
    chk("req_latency", n, 32'd1);
    chk("req_onehot", {30'd0, sdram_wr_req, sdram_rd_req}, v.we ? 32'd2 : 32'd1);
    chk("sys_addr", {10'd0, sys_addr}, {10'd0, v.exp_addr});
    chk("sys_data_in", {16'd0, sys_data_in}, {16'd0, v.dat});
    chk("byteenable", {30'd0, sdram_byteenable}, {30'd0, v.exp_be});
    chk("dqm", {30'd0, dqm_h, dqm_l}, {30'd0, v.exp_dqmh, v.exp_dqml});
    wb_adr = ~v.adr;  // outputs must not follow the bus after latching
    wb_dat_i = ~v.dat;
    wb_sel = ~v.sel;
    finish_txn(v.we, v.rdata, v.delay, v.exp_dato);
    chk("addr_stable", {10'd0, sys_addr}, {10'd0, v.exp_addr});
    chk("be_stable", {30'd0, sdram_byteenable}, {30'd0, v.exp_be});
  endtask

  vec_t tbl[5];
  vec_t rv;
  int   n;
  int   seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 2'b00, 21'h012345, 16'h0000, 16'hA5C3, 5, 22'h012345, 2'b11, 1'b0, 1'b0, 16'hA5C3};
    tbl[1] = '{1'b1, 2'b10, 21'h000100, 16'h1234, 16'h0000, 3, 22'h000100, 2'b10, 1'b0, 1'b1, 16'hA5C3};
    tbl[2] = '{1'b1, 2'b01, 21'h1FFFFF, 16'hBEEF, 16'h0000, 2, 22'h1FFFFF, 2'b01, 1'b1, 1'b0, 16'hA5C3};
    tbl[3] = '{1'b0, 2'b00, 21'h000000, 16'h7777, 16'h0F0F, 4, 22'h000000, 2'b11, 1'b0, 1'b0, 16'h0F0F};
    tbl[4] = '{1'b1, 2'b11, 21'h0AAAAA, 16'h5555, 16'h0000, 1, 22'h0AAAAA, 2'b11, 1'b0, 1'b0, 16'h0F0F};

    rst_n = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 2'b00; wb_adr = '0; wb_dat_i = '0;
    sdram_ready = 1'b1; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sys_data_out = '0;
    last_rd = 16'h0000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs", {sdram_wr_req, sdram_rd_req, wb_ack, wb_err, sdram_byteenable, dqm_h, dqm_l},
        32'b0000_1100);
    chk("rst_dat", {wb_dat_o, sys_data_in}, 32'd0);
    chk("rst_addr", {10'd0, sys_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);
    last_rd = 16'h0F0F;

    // Random transactions against the spec model.
    for (int k = 0; k < 20; k++) begin
      rv.we    = 1'($urandom);
      rv.sel   = 2'($urandom);
      rv.adr   = 21'($urandom);
      rv.dat   = 16'($urandom);
      rv.rdata = 16'($urandom);
      rv.delay = int'($urandom_range(1, 6));
      rv.exp_addr = {1'b0, rv.adr};
      rv.exp_be   = rv.we ? rv.sel : 2'b11;
      rv.exp_dqmh = rv.we ? ~rv.sel[1] : 1'b0;
      rv.exp_dqml = rv.we ? ~rv.sel[0] : 1'b0;
      rv.exp_dato = rv.we ? last_rd : rv.rdata;
      run_vec(rv);
    end

    // Controller not ready: strobe held, nothing issued until ready rises.
    @(negedge clk);
    sdram_ready = 1'b0;
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 21'h00BEEF;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sdram_wr_req || sdram_rd_req) seen++;
    end
    chk("not_ready_no_req", seen, 32'd0);
    sdram_ready = 1'b1;
    wait_req(n);
    chk("ready_req_latency", n, 32'd1);
    finish_txn(1'b0, 16'h1357, 1, 16'h1357);

    // Abort: strobe drops in WAIT, ack three cycles later, no wb_ack, IDLE at ack+1.
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 21'h000042;
    wait_req(n);
    @(negedge clk);
    wb_stb = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (wb_ack) seen++;
    end
    sdram_rd_ack = 1'b1;
    sys_data_out = 16'h2468;
    @(negedge clk);
    sdram_rd_ack = 1'b0;
    if (wb_ack) seen++;
    chk("abort_req_dropped", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
    wb_stb = 1'b1; wb_adr = 21'h000043;
    #1;
    if (wb_ack) seen++;
    chk("abort_no_ack", seen, 32'd0);
    wait_req(n);
    chk("abort_idle_at_m1", n, 32'd1);
    chk("abort_next_addr", {10'd0, sys_addr}, 32'h43);
    finish_txn(1'b0, 16'h9ABC, 2, 16'h9ABC);

    // Asynchronous reset in WAIT.
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b01; wb_adr = 21'h0F0F0F; wb_dat_i = 16'hCAFE;
    wait_req(n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {sdram_wr_req, sdram_rd_req, wb_ack, wb_err, sdram_byteenable, dqm_h, dqm_l},
        32'b0000_1100);
    chk("arst_dat", {wb_dat_o, sys_data_in}, 32'd0);
    chk("arst_addr", {10'd0, sys_addr}, 32'd0);
    @(negedge clk);
    wb_stb = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (sdram_wr_req || sdram_rd_req || wb_ack) seen++;
    end
    chk("arst_no_req_after", seen, 32'd0);
    last_rd = 16'h0000;

`ifdef SDRAM_TIMEOUT_EN
    // Watchdog: no ack, request held TIMEOUT_CYCLES WAIT cycles plus the REQ cycle.
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 21'h000777;
    wait_req(n);
    seen = 1;
    while ((sdram_wr_req || sdram_rd_req) && seen < 300) begin
      @(negedge clk);
      if (sdram_wr_req || sdram_rd_req) seen++;
    end
    chk("to_req_cycles", seen, TimeoutCycles + 1);
    chk("to_err", {31'd0, wb_err}, 32'd1);
    chk("to_dat", {16'd0, wb_dat_o}, 32'hFFFF);
    @(negedge clk);
    chk("to_ack", {31'd0, wb_ack}, 32'd1);
    @(negedge clk);
    chk("to_ack_held", {31'd0, wb_ack}, 32'd1);
    wb_stb = 1'b0;
    #1;
    chk("to_ack_drop", {31'd0, wb_ack}, 32'd0);
    @(negedge clk);
    chk("to_err_clear", {31'd0, wb_err}, 32'd0);
`else
    // Without the watchdog a missing ack just waits; complete it afterwards.
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 21'h000777;
    wait_req(n);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (!sdram_rd_req || wb_err || wb_ack) seen++;
    end
    chk("no_timeout_wait", seen, 32'd0);
    finish_txn(1'b0, 16'h4321, 1, 16'h4321);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
